siso_rowunit_sched: RTL and testbench

// Issue/writeback scheduler for the pipelined SISO row unit of the layered LDPC decoder.

---
 rtl/siso_rowunit_sched_if.sv | 35 +++
 rtl/siso_rowunit_sched.sv | 162 ++++++++++++++++
 tb/tb_siso_rowunit_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/siso_rowunit_sched_if.sv
// Handshake/strobe bundle between the SISO row-unit scheduler and its controller.
// The scheduler uses the slave modport. The controller or testbench uses the master modport.
interface siso_rowunit_sched_if #(
  parameter int LBITS     = 1,
  parameter int ADDRWIDTH = 5,
  parameter int ITBITS    = 4
);
  logic                       start;
  logic                       early_stop;
  logic                       rd_en;
  logic [LBITS-1:0]           rd_layer;
  logic [ADDRWIDTH-1:0]       rd_addr;
  logic                       e_wr_en;
  logic [LBITS+ADDRWIDTH-1:0] e_wr_la;
  logic                       d_rd_en;
  logic [LBITS+ADDRWIDTH-1:0] d_rd_la;
  logic                       llr_wr_en;
  logic [ADDRWIDTH-1:0]       llr_wr_addr;
  logic                       busy;
  logic                       done;
  logic [ITBITS-1:0]          iter_cnt;
  logic [15:0]                stall_cnt;

  modport master (
    output start, early_stop,
    input  rd_en, rd_layer, rd_addr, e_wr_en, e_wr_la, d_rd_en, d_rd_la,
           llr_wr_en, llr_wr_addr, busy, done, iter_cnt, stall_cnt
  );

  modport slave (
    input  start, early_stop,
    output rd_en, rd_layer, rd_addr, e_wr_en, e_wr_la, d_rd_en, d_rd_la,
           llr_wr_en, llr_wr_addr, busy, done, iter_cnt, stall_cnt
  );
endinterface

// File: rtl/siso_rowunit_sched.sv
// Issue/writeback scheduler for the pipelined SISO row unit of the layered LDPC decoder.
// Issues LLR/E reads, tracks them down a fixed pipe, and stalls on LLR read-after-write hazards.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing reads, bubbling on hazards
// S_DRAIN | no more issue, in-flight entries finish writeback
// S_DONE  | one-cycle done pulse
module siso_rowunit_sched #(
  parameter int LAYERS     = 2,
  parameter int LBITS      = 1,
  parameter int ADDRDEPTH  = 20,
  parameter int ADDRWIDTH  = 5,
  parameter int PIPESTAGES = 13,
  parameter int ETAP       = 9,
  parameter int DTAP       = 9,
  parameter int WBTAP      = 12,
  parameter int MAXITER    = 10,
  parameter int ITBITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  siso_rowunit_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [LBITS-1:0]     cand_layer_q, cand_layer_d;
  logic [ADDRWIDTH-1:0] cand_addr_q, cand_addr_d;
  logic [ITBITS-1:0]    iter_q, iter_d;
  logic [15:0]          stall_q, stall_d;
  logic                 rd_en_q, rd_en_d;
  logic [LBITS-1:0]     rd_layer_q, rd_layer_d;
  logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PIPESTAGES-1:0] pv_q, pv_d;
  logic [LBITS-1:0]     pl_q [PIPESTAGES];
  logic [LBITS-1:0]     pl_d [PIPESTAGES];
  logic [ADDRWIDTH-1:0] pa_q [PIPESTAGES];
  logic [ADDRWIDTH-1:0] pa_d [PIPESTAGES];
  logic                 hazard;
  logic                 pipe_empty;
  logic                 last_issue;

  // The WBTAP stage counts as in flight: LLR memory is read-first on a same-address collision.
  always_comb begin
    hazard = rd_en_q && (rd_addr_q == cand_addr_q);
    for (int k = 0; k <= WBTAP; k++) begin
      if (pv_q[k] && (pa_q[k] == cand_addr_q)) hazard = 1'b1;
    end
  end

  assign pipe_empty = !rd_en_q && (pv_q == '0);
  assign last_issue = (cand_layer_q == LBITS'(LAYERS - 1)) &&
                      (cand_addr_q == ADDRWIDTH'(ADDRDEPTH - 1)) &&
                      (iter_q == ITBITS'(MAXITER - 1));

  always_comb begin
    pv_d    = {pv_q[PIPESTAGES-2:0], rd_en_q};
    pl_d[0] = rd_layer_q;
    pa_d[0] = rd_addr_q;
    for (int k = 1; k < PIPESTAGES; k++) begin
      pl_d[k] = pl_q[k-1];
      pa_d[k] = pa_q[k-1];
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_layer_d = cand_layer_q;
    cand_addr_d  = cand_addr_q;
    iter_d       = iter_q;
    stall_d      = stall_q;
    rd_en_d      = 1'b0;
    rd_layer_d   = rd_layer_q;
    rd_addr_d    = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_RUN;
          cand_layer_d = '0;
          cand_addr_d  = '0;
          iter_d       = '0;
          stall_d      = '0;
        end
      end
      S_RUN: begin
        if (bus.early_stop) begin
          state_d = S_DRAIN;
        end else if (hazard) begin
          if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else begin
          rd_en_d    = 1'b1;
          rd_layer_d = cand_layer_q;
          rd_addr_d  = cand_addr_q;
          if (cand_addr_q == ADDRWIDTH'(ADDRDEPTH - 1)) begin
            cand_addr_d = '0;
            if (cand_layer_q == LBITS'(LAYERS - 1)) begin
              cand_layer_d = '0;
              iter_d       = iter_q + 1'b1;
            end else begin
              cand_layer_d = cand_layer_q + 1'b1;
            end
          end else begin
            cand_addr_d = cand_addr_q + 1'b1;
          end
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (pipe_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cand_layer_q <= '0;
      cand_addr_q  <= '0;
      iter_q       <= '0;
      stall_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_layer_q   <= '0;
      rd_addr_q    <= '0;
      pv_q         <= '0;
      for (int k = 0; k < PIPESTAGES; k++) begin
        pl_q[k] <= '0;
        pa_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cand_layer_q <= cand_layer_d;
      cand_addr_q  <= cand_addr_d;
      iter_q       <= iter_d;
      stall_q      <= stall_d;
      rd_en_q      <= rd_en_d;
      rd_layer_q   <= rd_layer_d;
      rd_addr_q    <= rd_addr_d;
      pv_q         <= pv_d;
      for (int k = 0; k < PIPESTAGES; k++) begin
        pl_q[k] <= pl_d[k];
        pa_q[k] <= pa_d[k];
      end
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_layer    = rd_layer_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.e_wr_en     = pv_q[ETAP];
  assign bus.e_wr_la     = {pl_q[ETAP], pa_q[ETAP]};
  assign bus.d_rd_en     = pv_q[DTAP];
  assign bus.d_rd_la     = {pl_q[DTAP], pa_q[DTAP]};
  assign bus.llr_wr_en   = pv_q[WBTAP];
  assign bus.llr_wr_addr = pa_q[WBTAP];
  assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.iter_cnt    = iter_q;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_siso_rowunit_sched.sv
// Directed bench for siso_rowunit_sched: default configuration plus a 2x4, single-iteration
// instance that exercises read-after-write stalls.
module tb_siso_rowunit_sched;
  localparam int ETAP = 9;
  localparam int DTAP = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  siso_rowunit_sched_if #(.LBITS(1), .ADDRWIDTH(5), .ITBITS(4)) bus_a ();
  siso_rowunit_sched_if #(.LBITS(1), .ADDRWIDTH(5), .ITBITS(4)) bus_b ();

  siso_rowunit_sched u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  siso_rowunit_sched #(.ADDRDEPTH(4), .MAXITER(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  typedef struct { int e; logic [5:0] la; } ent_t;
  ent_t q_e[$];
  ent_t q_d[$];
  int rd_cnt_a = 0, llr_cnt_a = 0, done_cnt_a = 0, run_a = 0, max_run_a = 0;
  int e_err = 0, d_err = 0, tap_err = 0;
  int rd_cnt_b = 0, llr_cnt_b = 0, min_gap_b = 1000;
  int last_b [32];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    ent_t ent;
    if (bus_a.rd_en === 1'b1) begin
      rd_cnt_a++;
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
      q_e.push_back('{edge_n, {bus_a.rd_layer, bus_a.rd_addr}});
      q_d.push_back('{edge_n, {bus_a.rd_layer, bus_a.rd_addr}});
    end else begin
      run_a = 0;
    end
    if (bus_a.e_wr_en === 1'b1) begin
      if (q_e.size() == 0) e_err++;
      else begin
        ent = q_e.pop_front();
        if (ent.la !== bus_a.e_wr_la || edge_n - ent.e != ETAP + 1) e_err++;
      end
    end
    if (bus_a.d_rd_en === 1'b1) begin
      if (q_d.size() == 0) d_err++;
      else begin
        ent = q_d.pop_front();
        if (ent.la !== bus_a.d_rd_la || edge_n - ent.e != DTAP + 1) d_err++;
      end
    end
    if (bus_a.e_wr_en !== bus_a.d_rd_en || bus_a.e_wr_la !== bus_a.d_rd_la) tap_err++;
    if (bus_a.llr_wr_en === 1'b1) llr_cnt_a++;
    if (bus_a.done === 1'b1) done_cnt_a++;
    if (!rst) begin
      q_e.delete();
      q_d.delete();
      run_a = 0;
    end
  end

  // Same-address reads on the small instance must be at least one full hazard window apart.
  always @(negedge clk) begin
    if (bus_b.rd_en === 1'b1) begin
      rd_cnt_b++;
      if (last_b[bus_b.rd_addr] >= 0 && edge_n - last_b[bus_b.rd_addr] < min_gap_b)
        min_gap_b = edge_n - last_b[bus_b.rd_addr];
      last_b[bus_b.rd_addr] = edge_n;
    end
    if (bus_b.llr_wr_en === 1'b1) llr_cnt_b++;
  end

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (bus_a.done !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, 32'(bus_a.done), 1);
  endtask

  initial begin
    int base_rd, base_llr, base_done, start_edge, n;
    for (int i = 0; i < 32; i++) last_b[i] = -1;
    bus_a.start = 1'b0; bus_a.early_stop = 1'b0;
    bus_b.start = 1'b0; bus_b.early_stop = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    chk("rst_rd_en", 32'(bus_a.rd_en), 0);
    chk("rst_e_la", 32'(bus_a.e_wr_la), 0);
    chk("rst_llr", 32'(bus_a.llr_wr_en), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_done", 32'(bus_a.done), 0);
    chk("rst_iter", 32'(bus_a.iter_cnt), 0);
    tick();

    // Full default decode: 400 back-to-back issues, no stalls.
    base_rd = rd_cnt_a; base_llr = llr_cnt_a;
    start_edge = edge_n + 1;
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    n = 0;
    while (bus_a.llr_wr_en !== 1'b1 && n < 50) begin tick(); n++; end
    chk("first_llr_lat", edge_n - start_edge, 14);
    wait_done_a("full_done", 1000);
    chk("full_iter", 32'(bus_a.iter_cnt), 10);
    chk("full_stall", 32'(bus_a.stall_cnt), 0);
    chk("full_rd", rd_cnt_a - base_rd, 400);
    chk("full_llr", llr_cnt_a - base_llr, 400);
    chk("full_run", max_run_a, 400);
    tick();
    chk("idle_busy", 32'(bus_a.busy), 0);

    // Small config: layer-1 addr 0 waits 11 bubbles, later addrs are already clear.
    bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
    n = 0;
    while (bus_b.done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("small_done", 32'(bus_b.done), 1);
    chk("small_stall", 32'(bus_b.stall_cnt), 11);
    chk("small_iter", 32'(bus_b.iter_cnt), 1);
    chk("small_rd", rd_cnt_b, 8);
    chk("small_gap", min_gap_b, 15);
    tick(); tick();
    chk("small_llr", llr_cnt_b, 8);

    // early_stop right after the 25th issue.
    base_rd = rd_cnt_a; base_llr = llr_cnt_a;
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 25; i++) begin
      tick();
      if (bus_a.rd_en === 1'b1) n++;
    end
    bus_a.early_stop = 1'b1; tick(); bus_a.early_stop = 1'b0;
    wait_done_a("es_done", 100);
    chk("es_rd", rd_cnt_a - base_rd, 25);
    chk("es_llr", llr_cnt_a - base_llr, 25);
    chk("es_iter", 32'(bus_a.iter_cnt), 0);
    tick();

    // Reset mid-RUN, then restart from layer 0, addr 0.
    base_done = done_cnt_a;
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    repeat (30) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mr_rd_en", 32'(bus_a.rd_en), 0);
    chk("mr_e_en", 32'(bus_a.e_wr_en), 0);
    chk("mr_d_en", 32'(bus_a.d_rd_en), 0);
    chk("mr_llr", 32'(bus_a.llr_wr_en), 0);
    chk("mr_busy", 32'(bus_a.busy), 0);
    repeat (20) tick();
    chk("mr_no_done", done_cnt_a - base_done, 0);
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    n = 0;
    while (bus_a.rd_en !== 1'b1 && n < 10) begin tick(); n++; end
    chk("mr_layer", 32'(bus_a.rd_layer), 0);
    chk("mr_addr", 32'(bus_a.rd_addr), 0);
    wait_done_a("mr_done", 1000);
    tick();

    // start held high: one done per decode, then a fresh decode from IDLE.
    base_rd = rd_cnt_a; base_done = done_cnt_a;
    bus_a.start = 1'b1;
    tick();
    wait_done_a("held_done", 1000);
    chk("held_rd", rd_cnt_a - base_rd, 400);
    chk("held_iter", 32'(bus_a.iter_cnt), 10);
    tick();
    chk("held_one_done", done_cnt_a - base_done, 1);
    tick();
    chk("held_restart", 32'(bus_a.busy), 1);
    chk("held_iter_clr", 32'(bus_a.iter_cnt), 0);
    bus_a.start = 1'b0;
    tick();
    chk("held_still_one", done_cnt_a - base_done, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    tick();

    chk("e_addr_stream", e_err, 0);
    chk("d_addr_stream", d_err, 0);
    chk("e_d_taps_equal", tap_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
